// File: rtl/nvme_pkg.sv
// Shared types for the NVMe action-side AXI-Lite register master.
// Holds the transaction FSM state encoding and the AXI response codes.
package nvme_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DRAIN   = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/nvme_action_lite_master.sv
// Single-outstanding AXI-Lite master that turns action register requests into
// AXI-Lite reads/writes, with a watchdog that completes stuck transactions.
`ifndef HOST_ADDR_BITS
`define HOST_ADDR_BITS 64
`endif

module nvme_action_lite_master
    import nvme_pkg::*;
#(
    parameter int ADDR_BITS      = `HOST_ADDR_BITS,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 axi_aclk,
    input  logic                 axi_aresetn,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [31:0]          req_wdata,

    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic [1:0]           rsp_resp,

    output logic [ADDR_BITS-1:0] host_m_axi_awaddr,
    output logic                 host_m_axi_awvalid,
    input  logic                 host_m_axi_awready,
    output logic [31:0]          host_m_axi_wdata,
    output logic [3:0]           host_m_axi_wstrb,
    output logic                 host_m_axi_wvalid,
    input  logic                 host_m_axi_wready,
    input  logic [1:0]           host_m_axi_bresp,
    input  logic                 host_m_axi_bvalid,
    output logic                 host_m_axi_bready,
    output logic [ADDR_BITS-1:0] host_m_axi_araddr,
    output logic                 host_m_axi_arvalid,
    input  logic                 host_m_axi_arready,
    input  logic [31:0]          host_m_axi_rdata,
    input  logic [1:0]           host_m_axi_rresp,
    input  logic                 host_m_axi_rvalid,
    output logic                 host_m_axi_rready
);

    localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);

    state_e              state;
    logic [CNT_BITS-1:0] cnt;
    logic                is_write;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic busy, done_hs, timeout_hit;

    assign aw_hs = host_m_axi_awvalid && host_m_axi_awready;
    assign w_hs  = host_m_axi_wvalid  && host_m_axi_wready;
    assign b_hs  = host_m_axi_bvalid  && host_m_axi_bready;
    assign ar_hs = host_m_axi_arvalid && host_m_axi_arready;
    assign r_hs  = host_m_axi_rvalid  && host_m_axi_rready;

    assign busy        = state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
    assign done_hs     = (state == WR_RESP && b_hs) || (state == RD_RESP && r_hs);
    // cnt equals the number of edges since acceptance, so firing at T-1 puts the pulse in cycle T.
    assign timeout_hit = (cnt == CNT_BITS'(TIMEOUT_CYCLES - 1));

    assign host_m_axi_wstrb = 4'hF;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state              <= IDLE;
            cnt                <= '0;
            is_write           <= 1'b0;
            req_ready          <= 1'b0;
            rsp_valid          <= 1'b0;
            rsp_rdata          <= '0;
            rsp_resp           <= RESP_OKAY;
            host_m_axi_awaddr  <= '0;
            host_m_axi_awvalid <= 1'b0;
            host_m_axi_wdata   <= '0;
            host_m_axi_wvalid  <= 1'b0;
            host_m_axi_bready  <= 1'b0;
            host_m_axi_araddr  <= '0;
            host_m_axi_arvalid <= 1'b0;
            host_m_axi_rready  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; a later assignment in
            // this block overrides an earlier one, which the timeout path relies on.
            rsp_valid <= 1'b0;
            if (busy)  cnt                <= cnt + CNT_BITS'(1);
            if (aw_hs) host_m_axi_awvalid <= 1'b0;
            if (w_hs)  host_m_axi_wvalid  <= 1'b0;
            if (ar_hs) host_m_axi_arvalid <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        cnt       <= CNT_BITS'(1);
                        is_write  <= req_write;
                        if (req_write) begin
                            host_m_axi_awaddr  <= req_addr;
                            host_m_axi_wdata   <= req_wdata;
                            host_m_axi_awvalid <= 1'b1;
                            host_m_axi_wvalid  <= 1'b1;
                            state              <= WR_REQ;
                        end else begin
                            host_m_axi_araddr  <= req_addr;
                            host_m_axi_arvalid <= 1'b1;
                            state              <= RD_REQ;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if ((aw_hs || !host_m_axi_awvalid) && (w_hs || !host_m_axi_wvalid)) begin
                        state             <= WR_RESP;
                        host_m_axi_bready <= 1'b1;
                    end
                end
                RD_REQ: begin
                    if (ar_hs) begin
                        state             <= RD_RESP;
                        host_m_axi_rready <= 1'b1;
                    end
                end
                WR_RESP, RD_RESP: begin
                    if (done_hs) begin
                        rsp_valid         <= 1'b1;
                        rsp_resp          <= is_write ? host_m_axi_bresp : host_m_axi_rresp;
                        rsp_rdata         <= is_write ? 32'h0 : host_m_axi_rdata;
                        state             <= IDLE;
                        cnt               <= '0;
                        host_m_axi_bready <= 1'b0;
                        host_m_axi_rready <= 1'b0;
                    end
                end
                DRAIN: begin
                    // The late response is swallowed; the requester already saw the timeout.
                    if (is_write ? b_hs : r_hs) begin
                        state             <= IDLE;
                        req_ready         <= 1'b1;
                        host_m_axi_bready <= 1'b0;
                        host_m_axi_rready <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (busy && timeout_hit && !done_hs) begin
                rsp_valid         <= 1'b1;
                rsp_resp          <= RESP_DECERR;
                rsp_rdata         <= '0;
                state             <= DRAIN;
                cnt               <= '0;
                host_m_axi_bready <= 1'b1;
                host_m_axi_rready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nvme_action_lite_master.sv
// Directed and randomized bench for nvme_action_lite_master with a reactive
// AXI-Lite slave and a timing/data reference model derived from wait counts.
module tb_nvme_action_lite_master;
    import nvme_pkg::*;

    localparam int AB = 32;
    localparam int TO = 16;

    logic          axi_aclk;
    logic          axi_aresetn;
    logic          req_valid, req_ready, req_write;
    logic [AB-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AB-1:0] host_m_axi_awaddr, host_m_axi_araddr;
    logic          host_m_axi_awvalid, host_m_axi_awready;
    logic [31:0]   host_m_axi_wdata, host_m_axi_rdata;
    logic [3:0]    host_m_axi_wstrb;
    logic          host_m_axi_wvalid, host_m_axi_wready;
    logic [1:0]    host_m_axi_bresp, host_m_axi_rresp;
    logic          host_m_axi_bvalid, host_m_axi_bready;
    logic          host_m_axi_arvalid, host_m_axi_arready;
    logic          host_m_axi_rvalid, host_m_axi_rready;

    nvme_action_lite_master #(.ADDR_BITS(AB), .TIMEOUT_CYCLES(TO)) dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .host_m_axi_awaddr(host_m_axi_awaddr), .host_m_axi_awvalid(host_m_axi_awvalid),
        .host_m_axi_awready(host_m_axi_awready), .host_m_axi_wdata(host_m_axi_wdata),
        .host_m_axi_wstrb(host_m_axi_wstrb), .host_m_axi_wvalid(host_m_axi_wvalid),
        .host_m_axi_wready(host_m_axi_wready), .host_m_axi_bresp(host_m_axi_bresp),
        .host_m_axi_bvalid(host_m_axi_bvalid), .host_m_axi_bready(host_m_axi_bready),
        .host_m_axi_araddr(host_m_axi_araddr), .host_m_axi_arvalid(host_m_axi_arvalid),
        .host_m_axi_arready(host_m_axi_arready), .host_m_axi_rdata(host_m_axi_rdata),
        .host_m_axi_rresp(host_m_axi_rresp), .host_m_axi_rvalid(host_m_axi_rvalid),
        .host_m_axi_rready(host_m_axi_rready)
    );

    initial begin
        axi_aclk = 1'b0;
        forever #5 axi_aclk = ~axi_aclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference register contents (from requests) and slave storage (from the bus).
    logic [31:0] model_mem [8];
    logic [31:0] slave_mem [8];

    int          r_n_rsp, r_rsp_c, r_rdy_c, r_aw_last, r_w_last, r_aw_hs, r_w_hs, r_proto;
    logic [1:0]  r_resp;
    logic [31:0] r_rdata;

    task automatic clear_slave();
        host_m_axi_awready = 1'b0; host_m_axi_wready = 1'b0;
        host_m_axi_bvalid  = 1'b0; host_m_axi_bresp  = 2'b00;
        host_m_axi_arready = 1'b0; host_m_axi_rvalid = 1'b0;
        host_m_axi_rdata   = '0;   host_m_axi_rresp  = 2'b00;
    endtask

    // d_a: AW/AR ready wait, d_w: W ready wait, d_r: B/R valid wait after address phase.
    task automatic run_txn(input bit wr, input int idx, input logic [31:0] data,
                           input int d_a, input int d_w, input int d_r,
                           input logic [1:0] code, input string tag);
        logic [AB-1:0] addr;
        logic [1:0]    exp_resp;
        logic [31:0]   exp_rdata;
        int  aw_hs = 0, w_hs = 0, ar_hs = 0, resp_hs = 0;
        int  hs_edge, exp_rsp, exp_rdy;
        bit  p_aw = 0, p_w = 0, p_ar = 0, bv, rv;
        addr = AB'(32'h40 + 4 * idx);
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge axi_aclk);
        check({tag, ":req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data;
        @(negedge axi_aclk);
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        r_n_rsp = 0; r_rsp_c = -1; r_rdy_c = -1; r_aw_last = -1; r_w_last = -1;
        r_aw_hs = -1; r_w_hs = -1; r_proto = 0; r_resp = 2'b00; r_rdata = '0;
        for (int c = 1; c <= 120; c++) begin
            if (rsp_valid) begin
                r_n_rsp++;
                if (r_n_rsp == 1) begin r_rsp_c = c; r_resp = rsp_resp; r_rdata = rsp_rdata; end
            end
            if (req_ready) begin r_rdy_c = c; break; end
            if (host_m_axi_awvalid) begin
                r_aw_last = c;
                if (!wr || host_m_axi_awaddr !== addr || aw_hs != 0) r_proto++;
            end
            if (host_m_axi_wvalid) begin
                r_w_last = c;
                if (!wr || host_m_axi_wdata !== data || host_m_axi_wstrb !== 4'hF || w_hs != 0) r_proto++;
            end
            if (host_m_axi_arvalid && (wr || host_m_axi_araddr !== addr || ar_hs != 0)) r_proto++;
            if ((p_aw && aw_hs == 0 && !host_m_axi_awvalid) || (p_w && w_hs == 0 && !host_m_axi_wvalid) ||
                (p_ar && ar_hs == 0 && !host_m_axi_arvalid)) r_proto++;
            host_m_axi_awready = wr && c >= 1 + d_a && aw_hs == 0;
            host_m_axi_wready  = wr && c >= 1 + d_w && w_hs == 0;
            bv = wr && aw_hs != 0 && w_hs != 0 && c >= ((aw_hs > w_hs) ? aw_hs : w_hs) + 1 + d_r && resp_hs == 0;
            host_m_axi_bvalid  = bv;
            host_m_axi_bresp   = bv ? code : 2'b00;
            host_m_axi_arready = !wr && c >= 1 + d_a && ar_hs == 0;
            rv = !wr && ar_hs != 0 && c >= ar_hs + 1 + d_r && resp_hs == 0;
            host_m_axi_rvalid  = rv;
            host_m_axi_rdata   = rv ? slave_mem[idx] : 32'h0;
            host_m_axi_rresp   = rv ? code : 2'b00;
            p_aw = host_m_axi_awvalid; p_w = host_m_axi_wvalid; p_ar = host_m_axi_arvalid;
            if (host_m_axi_awvalid && host_m_axi_awready) begin aw_hs = c; r_aw_hs = c; end
            if (host_m_axi_wvalid && host_m_axi_wready) begin
                w_hs = c; r_w_hs = c; slave_mem[idx] = host_m_axi_wdata;
            end
            if (host_m_axi_arvalid && host_m_axi_arready) ar_hs = c;
            if ((bv && host_m_axi_bready) || (rv && host_m_axi_rready)) resp_hs = c;
            @(negedge axi_aclk);
        end
        clear_slave();
        if (wr) begin
            hs_edge = 2 + ((d_a > d_w) ? d_a : d_w) + d_r;
            exp_rdata = 32'h0;
            model_mem[idx] = data;
        end else begin
            hs_edge = 2 + d_a + d_r;
            exp_rdata = model_mem[idx];
        end
        if (hs_edge <= TO - 1) begin
            exp_rsp = hs_edge + 1; exp_rdy = hs_edge + 2; exp_resp = code;
        end else begin
            exp_rsp = TO; exp_rdy = hs_edge + 1; exp_resp = 2'b11; exp_rdata = 32'h0;
        end
        check({tag, ":n_rsp"},     64'(r_n_rsp), 64'd1);
        check({tag, ":rsp_cycle"}, 64'(r_rsp_c), 64'(exp_rsp));
        check({tag, ":rsp_resp"},  64'(r_resp),  64'(exp_resp));
        check({tag, ":rsp_rdata"}, 64'(r_rdata), 64'(exp_rdata));
        check({tag, ":rdy_cycle"}, 64'(r_rdy_c), 64'(exp_rdy));
        check({tag, ":protocol"},  64'(r_proto), 64'd0);
    endtask

    function automatic logic any_output();
        return |{req_ready, rsp_valid, rsp_rdata, rsp_resp, host_m_axi_awaddr, host_m_axi_awvalid,
                 host_m_axi_wdata, host_m_axi_wvalid, host_m_axi_bready, host_m_axi_araddr,
                 host_m_axi_arvalid, host_m_axi_rready};
    endfunction

    initial begin
        int n_rsp;
        axi_aresetn = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        clear_slave();
        for (int i = 0; i < 8; i++) begin
            model_mem[i] = 32'hA5A5_0000 + 32'(i);
            slave_mem[i] = 32'hA5A5_0000 + 32'(i);
        end
        model_mem[1] = 32'hDEAD_BEEF;
        slave_mem[1] = 32'hDEAD_BEEF;

        #1 check("reset:outputs", 64'(any_output()), 64'd0);
        repeat (2) @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        #1 check("reset:ready_low_before_clock", 64'(req_ready), 64'd0);
        @(negedge axi_aclk);
        check("reset:ready_after_clock", 64'(req_ready), 64'd1);

        run_txn(1'b1, 0, 32'h1234_5678, 0, 0, 0, RESP_OKAY, "wr_zero_wait");
        check("wr_zero_wait:aw_hs_cycle", 64'(r_aw_hs), 64'd1);
        check("wr_zero_wait:w_hs_cycle",  64'(r_w_hs),  64'd1);

        run_txn(1'b0, 1, 32'h0, 0, 0, 2, RESP_OKAY, "rd_wait2");

        run_txn(1'b1, 3, 32'hCAFE_F00D, 0, 3, 0, RESP_OKAY, "wr_wready_late");
        check("wr_wready_late:aw_last", 64'(r_aw_last), 64'd1);
        check("wr_wready_late:w_last",  64'(r_w_last),  64'd4);

        run_txn(1'b0, 0, 32'h0, 1, 0, 1, RESP_SLVERR, "rd_back_slverr");
        run_txn(1'b1, 4, 32'h0BAD_0BAD, 0, 0, 28, RESP_OKAY, "wr_timeout");
        run_txn(1'b0, 4, 32'h0, 0, 0, 0, RESP_OKAY, "rd_after_timeout");
        run_txn(1'b0, 5, 32'h0, 0, 0, 13, RESP_OKAY, "rd_last_cycle");
        run_txn(1'b0, 5, 32'h0, 0, 0, 14, RESP_OKAY, "rd_first_timeout");
        run_txn(1'b0, 6, 32'h0, 20, 0, 0, RESP_OKAY, "rd_ar_timeout");
        run_txn(1'b1, 7, 32'h7777_1111, 18, 2, 0, RESP_OKAY, "wr_aw_timeout");

        // Reset while the read is waiting for R.
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge axi_aclk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = AB'(32'h48);
        @(negedge axi_aclk);
        req_valid = 1'b0; req_addr = '0;
        host_m_axi_arready = 1'b1;
        @(negedge axi_aclk);
        host_m_axi_arready = 1'b0;
        check("midrst:in_rd_resp", 64'(host_m_axi_rready), 64'd1);
        #2 axi_aresetn = 1'b0;
        #1 check("midrst:outputs", 64'(any_output()), 64'd0);
        host_m_axi_rvalid = 1'b1; host_m_axi_rdata = 32'h5555_AAAA;
        n_rsp = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge axi_aclk);
            if (rsp_valid) n_rsp++;
        end
        clear_slave();
        axi_aresetn = 1'b1;
        #1 check("midrst:ready_low_before_clock", 64'(req_ready), 64'd0);
        @(negedge axi_aclk);
        if (rsp_valid) n_rsp++;
        check("midrst:no_rsp", 64'(n_rsp), 64'd0);
        check("midrst:ready_after_clock", 64'(req_ready), 64'd1);
        run_txn(1'b0, 2, 32'h0, 0, 0, 0, RESP_OKAY, "rd_after_reset");

        for (int t = 0; t < 24; t++) begin
            bit          wr;
            int          idx, d_a, d_w, d_r;
            logic [1:0]  code;
            logic [31:0] data;
            wr   = 1'($urandom_range(0, 1));
            idx  = int'($urandom_range(0, 7));
            data = $urandom;
            d_a  = int'($urandom_range(0, 4));
            d_w  = int'($urandom_range(0, 4));
            d_r  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(10, 16)) : int'($urandom_range(0, 3));
            code = 2'($urandom_range(0, 3));
            run_txn(wr, idx, data, d_a, d_w, d_r, code, $sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nvme_action_lite_master.md
NVME_ACTION_LITE_MASTER -- requirements
Module: nvme_action_lite_master

Interface
REQ-001 SHALL have parameter ADDR_BITS, default `HOST_ADDR_BITS, width of request address and AXI-Lite addresses.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, cycles from request acceptance to forced timeout completion.
REQ-003 SHALL have port axi_aclk  in  1  single clock, all logic rising-edge.
REQ-004 SHALL have port axi_aresetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  1  action requests a register access.
REQ-006 SHALL have port req_ready  out  1  block accepts request (high only in IDLE).
REQ-007 SHALL have port req_write  in  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  in  ADDR_BITS  register byte address.
REQ-009 SHALL have port req_wdata  in  32  write data.
REQ-010 SHALL have port rsp_valid  out  1  one-cycle completion pulse, no backpressure.
REQ-011 SHALL have port rsp_rdata  out  32  read data, 0 for writes and timeouts.
REQ-012 SHALL have port rsp_resp  out  2  AXI response code; 2'b11 on timeout.
REQ-013 SHALL have port host_m_axi_awaddr  out  ADDR_BITS  write address.
REQ-014 SHALL have port host_m_axi_awvalid  out  1  write address valid.
REQ-015 SHALL have port host_m_axi_awready  in  1  write address ready.
REQ-016 SHALL have port host_m_axi_wdata  out  32  write data.
REQ-017 SHALL have port host_m_axi_wstrb  out  4  constant 4'hF.
REQ-018 SHALL have port host_m_axi_wvalid  out  1  write data valid.
REQ-019 SHALL have port host_m_axi_wready  in  1  write data ready.
REQ-020 SHALL have port host_m_axi_bresp  in  2  write response.
REQ-021 SHALL have port host_m_axi_bvalid  in  1  write response valid.
REQ-022 SHALL have port host_m_axi_bready  out  1  write response ready.
REQ-023 SHALL have port host_m_axi_araddr  out  ADDR_BITS  read address.
REQ-024 SHALL have port host_m_axi_arvalid  out  1  read address valid.
REQ-025 SHALL have port host_m_axi_arready  in  1  read address ready.
REQ-026 SHALL have port host_m_axi_rdata  in  32  read data.
REQ-027 SHALL have port host_m_axi_rresp  in  2  read response.
REQ-028 SHALL have port host_m_axi_rvalid  in  1  read data valid.
REQ-029 SHALL have port host_m_axi_rready  out  1  read data ready.

Function
REQ-030 SHALL implement FSM IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DRAIN; one transaction outstanding at a time.
REQ-031 SHALL on req_valid&&req_ready register addr/data and, next cycle, assert awvalid+wvalid (write, WR_REQ) or arvalid (read, RD_REQ).
REQ-032 SHALL track AW and W handshakes independently: each valid drops the cycle after its own handshake; WR_REQ->WR_RESP once both done, including same-cycle completion.
REQ-033 SHALL hold bready high only in WR_RESP/DRAIN, rready high only in RD_RESP/DRAIN; RD_REQ->RD_RESP on arvalid&&arready.
REQ-034 SHALL pulse rsp_valid one cycle after the B or R handshake, with rsp_resp = bresp/rresp and rsp_rdata = rdata (reads); FSM to IDLE same cycle as pulse; minimum request-to-rsp_valid latency 3 cycles with zero-wait slave.
REQ-035 SHALL keep AXI outputs stable while valid is high and never drop a valid before its handshake.
REQ-036 SHALL count cycles from acceptance; at TIMEOUT_CYCLES without completion pulse rsp_valid with rsp_resp 2'b11, rsp_rdata 0, enter DRAIN.
REQ-037 SHALL in DRAIN keep pending valids asserted, complete outstanding handshakes, discard the late response without rsp_valid, then return to IDLE; req_ready low throughout.
REQ-038 SHALL raise req_ready in the cycle after rsp_valid, allowing back-to-back requests.

Reset
REQ-039 SHALL on axi_aresetn low asynchronously force IDLE, counter 0, all valids/readies/rsp_valid 0, rsp_rdata 0, rsp_resp 0, req_ready 0 until first clock after release; mid-transaction reset abandons the transaction silently.

Structure
REQ-040 SHALL place the FSM state enum and response codes (OKAY, SLVERR, DECERR) in shared package nvme_pkg; ADDR_BITS default from nvme_defines; no sub-modules.

Verification
REQ-041 Write 0x12345678 to 0x40, zero-wait slave, bresp 0 -> aw/w handshake cycle 1, rsp_valid cycle 3, rsp_resp 0.
REQ-042 Read 0x44, slave returns 0xDEADBEEF rresp 0 after 2 wait cycles -> rsp_rdata 0xDEADBEEF, single rsp_valid pulse.
REQ-043 Write with awready immediate, wready delayed 3 cycles -> awvalid drops after cycle 1, wvalid held to cycle 4, one completion.
REQ-044 TIMEOUT_CYCLES=16, slave never asserts bvalid until cycle 30 -> rsp_resp 2'b11 at cycle 16, late B consumed silently, req_ready high cycle 31.
REQ-045 Assert axi_aresetn low while in RD_RESP -> all outputs 0 immediately, no rsp_valid, next read after release completes normally.
